// File: rtl/stub_pkg.sv
// Shared types for the two-port round-robin resource arbiter.
// Holds FSM state encoding, requester identity and the default data width.
package stub_pkg;

  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT
  } arb_state_e;

  typedef enum logic {
    REQ_VIP,
    REQ_KELVIN
  } req_id_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant: sole valid requester wins, a tie goes to the
// requester that did not win last time. Purely combinational.
module rr_arb2
  import stub_pkg::*;
(
  input  logic    i_valid_vip,
  input  logic    i_valid_kelvin,
  input  req_id_e i_last_grant,
  output logic    o_grant_valid_c,
  output req_id_e o_grant_c
);

  always_comb begin
    o_grant_valid_c = i_valid_vip | i_valid_kelvin;
    o_grant_c       = REQ_VIP;
    if (i_valid_vip && i_valid_kelvin) begin
      o_grant_c = (i_last_grant == REQ_VIP) ? REQ_KELVIN : REQ_VIP;
    end else if (i_valid_kelvin) begin
      o_grant_c = REQ_KELVIN;
    end
  end

endmodule

// File: rtl/stub_arbiter.sv
// Shares one request/response resource between the vip_test and kelvin ports,
// one transaction in flight, with a response timeout that returns zero data.
module stub_arbiter
  import stub_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] data_o,
  output logic              rsp_valid_o,
  input  logic              kelvin_valid_i,
  input  logic [DATA_W-1:0] kelvin_data_i,
  output logic              kelvin_ready_o,
  output logic [DATA_W-1:0] kelvin_data_o,
  output logic              kelvin_rsp_valid_o,
  output logic              res_valid_o,
  output logic [DATA_W-1:0] res_data_o,
  input  logic              res_ready_i,
  input  logic              res_rsp_valid_i,
  input  logic [DATA_W-1:0] res_rsp_data_i,
  output logic              busy_o,
  output logic              timeout_o
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  arb_state_e        r_state,      w_state_nxt;
  req_id_e           r_owner,      w_owner_nxt;
  req_id_e           r_last_grant, w_last_nxt;
  logic [TMR_W-1:0]  r_timer,      w_timer_nxt;
  logic              r_res_valid,  w_res_valid_nxt;
  logic [DATA_W-1:0] r_res_data,   w_res_data_nxt;
  logic [DATA_W-1:0] r_data_vip,   w_data_vip_nxt;
  logic [DATA_W-1:0] r_data_kel,   w_data_kel_nxt;
  logic              r_rsp_vip,    w_rsp_vip_nxt;
  logic              r_rsp_kel,    w_rsp_kel_nxt;
  logic              r_timeout,    w_timeout_nxt;
  logic              r_busy,       w_busy_nxt;
  logic [DATA_W-1:0] w_rsp_data;

  logic    w_grant_valid;
  req_id_e w_grant;
  logic    w_accept;

  rr_arb2 u_rr_arb2 (
    .i_valid_vip     (valid_i),
    .i_valid_kelvin  (kelvin_valid_i),
    .i_last_grant    (r_last_grant),
    .o_grant_valid_c (w_grant_valid),
    .o_grant_c       (w_grant)
  );

  // Handshake is only offered in IDLE, and only to the current winner.
  assign w_accept       = (r_state == ST_IDLE) && w_grant_valid;
  assign ready_o        = w_accept && (w_grant == REQ_VIP);
  assign kelvin_ready_o = w_accept && (w_grant == REQ_KELVIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_owner      <= REQ_VIP;
      r_last_grant <= REQ_KELVIN;
      r_timer      <= '0;
      r_res_valid  <= 1'b0;
      r_res_data   <= '0;
      r_data_vip   <= '0;
      r_data_kel   <= '0;
      r_rsp_vip    <= 1'b0;
      r_rsp_kel    <= 1'b0;
      r_timeout    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_grant <= w_last_nxt;
      r_timer      <= w_timer_nxt;
      r_res_valid  <= w_res_valid_nxt;
      r_res_data   <= w_res_data_nxt;
      r_data_vip   <= w_data_vip_nxt;
      r_data_kel   <= w_data_kel_nxt;
      r_rsp_vip    <= w_rsp_vip_nxt;
      r_rsp_kel    <= w_rsp_kel_nxt;
      r_timeout    <= w_timeout_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  // Next-state and registered-output logic; pulses default low every cycle.
  always_comb begin
    w_state_nxt     = r_state;
    w_owner_nxt     = r_owner;
    w_last_nxt      = r_last_grant;
    w_timer_nxt     = r_timer;
    w_res_valid_nxt = r_res_valid;
    w_res_data_nxt  = r_res_data;
    w_data_vip_nxt  = r_data_vip;
    w_data_kel_nxt  = r_data_kel;
    w_rsp_vip_nxt   = 1'b0;
    w_rsp_kel_nxt   = 1'b0;
    w_timeout_nxt   = 1'b0;
    w_rsp_data      = '0;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_res_data_nxt  = (w_grant == REQ_VIP) ? data_i : kelvin_data_i;
          w_owner_nxt     = w_grant;
          w_last_nxt      = w_grant;
          w_res_valid_nxt = 1'b1;
          w_state_nxt     = ST_SEND;
        end
      end
      ST_SEND: begin
        if (res_ready_i) begin
          w_res_valid_nxt = 1'b0;
          w_timer_nxt     = '0;
          w_state_nxt     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        w_timer_nxt = r_timer + TMR_W'(1);
        // A response arriving on the last allowed cycle beats the timeout.
        if (res_rsp_valid_i || (r_timer == TMR_LAST)) begin
          w_rsp_data    = res_rsp_valid_i ? res_rsp_data_i : '0;
          w_timeout_nxt = !res_rsp_valid_i;
          if (r_owner == REQ_VIP) begin
            w_data_vip_nxt = w_rsp_data;
            w_rsp_vip_nxt  = 1'b1;
          end else begin
            w_data_kel_nxt = w_rsp_data;
            w_rsp_kel_nxt  = 1'b1;
          end
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  assign data_o             = r_data_vip;
  assign rsp_valid_o        = r_rsp_vip;
  assign kelvin_data_o      = r_data_kel;
  assign kelvin_rsp_valid_o = r_rsp_kel;
  assign res_valid_o        = r_res_valid;
  assign res_data_o         = r_res_data;
  assign busy_o             = r_busy;
  assign timeout_o          = r_timeout;

endmodule
